// File: rtl/text_writer_if.sv
// Byte-stream handshake into the text writer: the source drives a byte and
// in_valid, and the writer answers with in_ready. A byte moves on a px_clk
// edge where in_valid and in_ready are both high.
interface text_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/text_writer.sv
// text_writer: write-side controller for the 64x16 character display.
// It turns a byte stream into character-buffer writes, cursor updates and a
// hardware scroll offset (top_row). Buffer addresses are {physical row, col},
// where physical row = logical row + top_row (4-bit wrap).
// Optional feature: define TEXT_WRITER_CLEAR_SCREEN_EN so that form feed
// (0x0C) clears the whole buffer and homes the cursor and scroll offset.
module text_writer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic         px_clk,
  input  logic         clr,
  text_writer_if.slave in_if,
  output logic [7:0]   buffer_din,
  output logic [9:0]   buffer_waddr,
  output logic         buffer_wen,
  output logic [5:0]   new_cursor_x,
  output logic [3:0]   new_cursor_y,
  output logic         write_cursor_pos,
  output logic [3:0]   top_row
);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
  localparam logic [7:0] CH_FF = 8'h0C;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SCROLL_PEND,
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
    CLEAR_LINE,
    CLEAR_SCREEN
`else
    CLEAR_LINE
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] din_d;
  logic [9:0] waddr_d;
  logic       wen_d;
  logic [5:0] cur_x_d;
  logic [3:0] cur_y_d;
  logic       cur_strobe_d;
  logic [3:0] top_row_d;

  // Line-clear progress: the physical row being blanked and the next column.
  // The column counter wraps to 0 after column 63 is issued, which ends the clear.
  logic [5:0] clear_col_q, clear_col_d;
  logic [3:0] clear_row_q, clear_row_d;
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
  logic [9:0] screen_addr_q, screen_addr_d;
`endif

  logic       accept;
  logic       is_print;
  logic [3:0] phys_row;

  assign in_if.in_ready = (state_q == IDLE);
  assign accept         = in_if.in_valid && (state_q == IDLE);
  assign is_print       = (in_if.in_data >= 8'h20) && (in_if.in_data <= 8'h7E);
  assign phys_row       = new_cursor_y + top_row;

  // Next-state and next-output decode for the byte interpreter and clear sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    din_d         = buffer_din;
    waddr_d       = buffer_waddr;
    wen_d         = 1'b0;
    cur_x_d       = new_cursor_x;
    cur_y_d       = new_cursor_y;
    cur_strobe_d  = 1'b0;
    top_row_d     = top_row;
    clear_col_d   = clear_col_q;
    clear_row_d   = clear_row_q;
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
    screen_addr_d = screen_addr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cur_strobe_d = 1'b1;
          if (is_print) begin
            wen_d   = 1'b1;
            din_d   = in_if.in_data;
            waddr_d = {phys_row, new_cursor_x};
            cur_x_d = new_cursor_x + 6'd1;
            // Column 63 wraps to the next line; on the last line that scrolls,
            // and the line clear starts one cycle later from SCROLL_PEND.
            if (new_cursor_x == 6'd63) begin
              if (new_cursor_y != 4'd15) begin
                cur_y_d = new_cursor_y + 4'd1;
              end else begin
                top_row_d   = top_row + 4'd1;
                clear_row_d = top_row;
                state_d     = SCROLL_PEND;
              end
            end
          end else if (in_if.in_data == CH_LF) begin
            if (new_cursor_y != 4'd15) begin
              cur_y_d = new_cursor_y + 4'd1;
            end else begin
              // Scroll: the old top row becomes logical row 15; column 0 of
              // it is blanked right away, the rest follow in CLEAR_LINE.
              top_row_d   = top_row + 4'd1;
              clear_row_d = top_row;
              wen_d       = 1'b1;
              din_d       = FILL_CHAR;
              waddr_d     = {top_row, 6'd0};
              clear_col_d = 6'd1;
              state_d     = CLEAR_LINE;
            end
          end else if (in_if.in_data == CH_CR) begin
            cur_x_d = 6'd0;
          end else if (in_if.in_data == CH_BS) begin
            if (new_cursor_x != 6'd0) begin
              cur_x_d = new_cursor_x - 6'd1;
            end
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
          end else if (in_if.in_data == CH_FF) begin
            cur_x_d       = 6'd0;
            cur_y_d       = 4'd0;
            top_row_d     = 4'd0;
            wen_d         = 1'b1;
            din_d         = FILL_CHAR;
            waddr_d       = 10'd0;
            screen_addr_d = 10'd1;
            state_d       = CLEAR_SCREEN;
`endif
          end
        end
      end

      SCROLL_PEND: begin
        wen_d       = 1'b1;
        din_d       = FILL_CHAR;
        waddr_d     = {clear_row_q, 6'd0};
        clear_col_d = 6'd1;
        state_d     = CLEAR_LINE;
      end

      CLEAR_LINE: begin
        if (clear_col_q == 6'd0) begin
          state_d = IDLE;
        end else begin
          wen_d       = 1'b1;
          din_d       = FILL_CHAR;
          waddr_d     = {clear_row_q, clear_col_q};
          clear_col_d = clear_col_q + 6'd1;
        end
      end

`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
      CLEAR_SCREEN: begin
        if (screen_addr_q == 10'd0) begin
          state_d = IDLE;
        end else begin
          wen_d         = 1'b1;
          din_d         = FILL_CHAR;
          waddr_d       = screen_addr_q;
          screen_addr_d = screen_addr_q + 10'd1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; clr aborts any clear in progress at once.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      state_q          <= IDLE;
      buffer_din       <= 8'd0;
      buffer_waddr     <= 10'd0;
      buffer_wen       <= 1'b0;
      new_cursor_x     <= 6'd0;
      new_cursor_y     <= 4'd0;
      write_cursor_pos <= 1'b0;
      top_row          <= 4'd0;
      clear_col_q      <= 6'd0;
      clear_row_q      <= 4'd0;
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
      screen_addr_q    <= 10'd0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q          <= state_d;
      buffer_din       <= din_d;
      buffer_waddr     <= waddr_d;
      buffer_wen       <= wen_d;
      new_cursor_x     <= cur_x_d;
      new_cursor_y     <= cur_y_d;
      write_cursor_pos <= cur_strobe_d;
      top_row          <= top_row_d;
      clear_col_q      <= clear_col_d;
      clear_row_q      <= clear_row_d;
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
      screen_addr_q    <= screen_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer. A behavioural model keeps the cursor,
// scroll offset and a 1024-cell picture of the character buffer; the bench
// captures the DUT's buffer writes into its own array and compares both.
module tb_text_writer;

  localparam logic [7:0] FILL = 8'h20;

  logic px_clk = 1'b0;
  logic clr;
  logic [7:0] buffer_din;
  logic [9:0] buffer_waddr;
  logic       buffer_wen;
  logic [5:0] new_cursor_x;
  logic [3:0] new_cursor_y;
  logic       write_cursor_pos;
  logic [3:0] top_row;

  text_writer_if bus ();

  text_writer #(.FILL_CHAR(FILL)) dut (
    .px_clk           (px_clk),
    .clr              (clr),
    .in_if            (bus),
    .buffer_din       (buffer_din),
    .buffer_waddr     (buffer_waddr),
    .buffer_wen       (buffer_wen),
    .new_cursor_x     (new_cursor_x),
    .new_cursor_y     (new_cursor_y),
    .write_cursor_pos (write_cursor_pos),
    .top_row          (top_row)
  );

  always #5 px_clk = ~px_clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Captured buffer contents and event counts, sampled mid-cycle.
  logic [7:0] dut_mem [1024];
  int wr_cnt     = 0;
  int strobe_cnt = 0;

  always @(negedge px_clk) begin
    if (!clr) begin
      if (buffer_wen) begin
        dut_mem[buffer_waddr] = buffer_din;
        wr_cnt++;
      end
      if (write_cursor_pos) strobe_cnt++;
    end
  end

  // Reference model state.
  logic [7:0] model_mem [1024];
  int mx = 0, my = 0, mtop = 0;

  function automatic bit model_lf();
    if (my < 15) begin
      my++;
      return 1'b0;
    end
    for (int c = 0; c < 64; c++) model_mem[mtop * 64 + c] = FILL;
    mtop = (mtop + 1) % 16;
    return 1'b1;
  endfunction

  // Applies one byte to the model; reports the first write (address, data),
  // the total write count and how many cycles the writer stays busy.
  task automatic model_step(input logic [7:0] b, output int addr1, output logic [7:0] din1,
                            output int nwr, output int busy);
    addr1 = -1; din1 = 8'h00; nwr = 0; busy = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      addr1 = ((my + mtop) % 16) * 64 + mx;
      din1  = b;
      model_mem[addr1] = b;
      nwr = 1;
      if (mx == 63) begin
        mx = 0;
        if (model_lf()) begin
          nwr  = 65;
          busy = 65;
        end
      end else begin
        mx++;
      end
    end else if (b == 8'h0A) begin
      int old_top = mtop;
      if (model_lf()) begin
        addr1 = old_top * 64;
        din1  = FILL;
        nwr   = 64;
        busy  = 64;
      end
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h08) begin
      if (mx > 0) mx--;
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
    end else if (b == 8'h0C) begin
      for (int i = 0; i < 1024; i++) model_mem[i] = FILL;
      mx = 0; my = 0; mtop = 0;
      addr1 = 0; din1 = FILL; nwr = 1024; busy = 1024;
`endif
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (dut_mem[i] !== model_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    bit timed_out = 1'b0;
    while (bus.in_ready !== 1'b1) begin
      @(negedge px_clk);
      n++;
      if (n > 3000) begin
        timed_out = 1'b1;
        break;
      end
    end
    check("ready_timeout", timed_out, 0);
  endtask

  task automatic do_reset();
    @(negedge px_clk);
    clr = 1'b1;
    repeat (2) @(negedge px_clk);
    clr = 1'b0;
    mx = 0; my = 0; mtop = 0;
  endtask

  // Sends one byte with in_valid for a single accept edge and checks the
  // N+1 outputs, the busy window, write count and strobe count.
  task automatic send_byte(input logic [7:0] b);
    int addr1, nwr, busy, n, wr0, st0;
    logic [7:0] din1;
    wait_ready();
    @(negedge px_clk);
    #1;
    wr0 = wr_cnt;
    st0 = strobe_cnt;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    model_step(b, addr1, din1, nwr, busy);
    @(posedge px_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    check("strobe", write_cursor_pos, 1);
    check("cur_x", new_cursor_x, mx);
    check("cur_y", new_cursor_y, my);
    check("top_row", top_row, mtop);
    if (addr1 >= 0) begin
      check("wen_n1", buffer_wen, 1);
      check("waddr_n1", buffer_waddr, addr1);
      check("din_n1", buffer_din, din1);
    end else begin
      check("no_wen", buffer_wen, 0);
    end
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(posedge px_clk);
      #1;
      n++;
    end
    check("busy_cycles", n, busy);
    @(negedge px_clk);
    #1;
    check("write_count", wr_cnt - wr0, nwr);
    check("strobe_count", strobe_cnt - st0, 1);
  endtask

  // Starts a clear with byte b, asserts clr part-way through and checks the abort.
  task automatic abort_clear(input logic [7:0] b, input int delay, input string tag);
    int w0;
    wait_ready();
    @(negedge px_clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge px_clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (delay) @(posedge px_clk);
    @(negedge px_clk);
    check({tag, "_wen_before"}, buffer_wen, 1);
    check({tag, "_busy_before"}, bus.in_ready, 0);
    clr = 1'b1;
    #1;
    check({tag, "_wen"}, buffer_wen, 0);
    check({tag, "_ready"}, bus.in_ready, 1);
    check({tag, "_top"}, top_row, 0);
    check({tag, "_xy"}, {new_cursor_x, new_cursor_y}, 0);
    w0 = wr_cnt;
    @(negedge px_clk);
    clr = 1'b0;
    repeat (5) @(negedge px_clk);
    #1;
    check({tag, "_no_writes"}, wr_cnt - w0, 0);
    check({tag, "_ready_after"}, bus.in_ready, 1);
    mx = 0; my = 0; mtop = 0;
  endtask

  initial begin
    int addr1, nwr, busy, wr0, r;
    logic [7:0] din1, b;
    logic [7:0] others [7] = '{8'h00, 8'h07, 8'h09, 8'h1B, 8'h7F, 8'h80, 8'hFF};

    for (int i = 0; i < 1024; i++) begin
      dut_mem[i]   = 8'h00;
      model_mem[i] = 8'h00;
    end
    clr          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge px_clk);
    #1;

    // Reset values.
    check("rst_din", buffer_din, 0);
    check("rst_waddr", buffer_waddr, 0);
    check("rst_wen", buffer_wen, 0);
    check("rst_strobe", write_cursor_pos, 0);
    check("rst_xy", {new_cursor_x, new_cursor_y}, 0);
    check("rst_top", top_row, 0);
    check("rst_ready", bus.in_ready, 1);
    @(negedge px_clk);
    clr = 1'b0;

    // Single printable byte.
    send_byte(8'h41);

    // 65 printable bytes back to back from home: one accepted per cycle.
    do_reset();
    @(negedge px_clk);
    #1;
    wr0 = wr_cnt;
    for (int i = 0; i < 65; i++) begin
      b = 8'($urandom_range(32, 126));
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      check("burst_ready", bus.in_ready, 1);
      model_step(b, addr1, din1, nwr, busy);
      @(posedge px_clk);
      #1;
      check("burst_wen", buffer_wen, 1);
      check("burst_waddr", buffer_waddr, addr1);
      check("burst_din", buffer_din, b);
      check("burst_strobe", write_cursor_pos, 1);
    end
    bus.in_valid = 1'b0;
    check("burst_last_addr", addr1, 64);
    check("burst_x", new_cursor_x, mx);
    check("burst_y", new_cursor_y, my);
    @(negedge px_clk);
    #1;
    check("burst_writes", wr_cnt - wr0, 65);

    // Line feeds down to the last row, then a scrolling line feed.
    while (my < 15) send_byte(8'h0A);
    send_byte(8'h0A);
    compare_mem("mem_after_scroll");

    // Cursor at x=5, then BS, CR, BEL.
    send_byte(8'h0D);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(32, 126)));
    send_byte(8'h08);
    send_byte(8'h0D);
    send_byte(8'h07);

    // Randomized traffic mixing text and control codes.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32, 126));
      else if (r < 75) b = 8'h0A;
      else if (r < 80) b = 8'h0D;
      else if (r < 90) b = 8'h08;
      else if (r < 93) b = 8'h0C;
      else             b = others[$urandom_range(0, 6)];
      send_byte(b);
    end
    compare_mem("mem_after_random");

`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
    while (my < 15) send_byte(8'h0A);
    send_byte(8'h0A);
    send_byte(8'h0C);
    compare_mem("mem_after_ff");
`endif

    // Reset in the middle of a line clear.
    while (my < 15) send_byte(8'h0A);
    abort_clear(8'h0A, 10, "abort_line");
`ifdef TEXT_WRITER_CLEAR_SCREEN_EN
    abort_clear(8'h0C, 100, "abort_screen");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
